maxpool_fifo_bank: RTL and testbench

Parametrised successor to the per-lane maxpool FIFO array: NUM_FIFO lanes of DEPTH-entry storage share one set of read/write pointers. Adds occupancy/full/empty flags, sticky error flags, per-lane padding masks, and a max-merge write mode that folds a second input row into the stored row in place. It sits between the systolic array output and the maxpool stage, so 2x2/stride-2 pooling reduces rows without an external comparator bank.

---
 rtl/maxpool_pkg.sv | 26 ++
 rtl/maxpool_lane_mem.sv | 61 ++++++
 rtl/maxpool_fifo_bank.sv | 109 ++++++++++
 tb/tb_maxpool_fifo_bank.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/maxpool_pkg.sv
// rtl/maxpool_pkg.sv - shared widths, pad value and lane slicing for the maxpool FIFO bank
package maxpool_pkg;

    typedef struct packed {
        logic push;
        logic pop;
        logic merge;
        logic ovf_set;
        logic unf_set;
    } ctl_t;

    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Padding lanes must never win a max compare.
    function automatic logic [63:0] pad_value(input int dw, input bit signed_mode);
        if (signed_mode) return 64'd1 << (dw - 1);
        return 64'd0;
    endfunction

    function automatic int lane_lsb(input int lane, input int dw);
        return lane * dw;
    endfunction

endpackage

// File: rtl/maxpool_lane_mem.sv
// rtl/maxpool_lane_mem.sv - one lane: storage, head read, max/pad select, registered output
module maxpool_lane_mem
    import maxpool_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16,
    parameter bit SIGNED     = 1'b1,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic                  merge_i,
    input  logic                  pop_i,
    input  logic                  mask_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    input  logic [AW-1:0]         wr_addr_i,
    input  logic [AW-1:0]         rd_addr_i,
    output logic [DATA_WIDTH-1:0] dout_o
);

    localparam logic [DATA_WIDTH-1:0] PAD = DATA_WIDTH'(pad_value(DATA_WIDTH, SIGNED));

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  din_greater;

    assign head        = mem_q[rd_addr_i];
    assign din_greater = SIGNED ? ($signed(din_i) > $signed(head)) : (din_i > head);

    always_comb begin
        wdata = head;
        if (push_i) begin
            wdata = mask_i ? din_i : PAD;
        end else if (mask_i && din_greater) begin
            wdata = din_i;
        end
    end

    // A merge on a full FIFO writes over the head it just consumed.
    always_ff @(posedge clk) begin
        if (push_i || merge_i) begin
            mem_q[wr_addr_i] <= wdata;
        end
    end

    always_comb begin
        dout_d = dout_q;
        if (pop_i) dout_d = head;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dout_q <= '0;
        else        dout_q <= dout_d;
    end

    assign dout_o = dout_q;

endmodule

// File: rtl/maxpool_fifo_bank.sv
// rtl/maxpool_fifo_bank.sv - NUM_FIFO lanes sharing pointers, with flags and in-place max-merge
module maxpool_fifo_bank
    import maxpool_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16,
    parameter int NUM_FIFO   = 16,
    parameter bit SIGNED     = 1'b1,
    localparam int PW        = ptr_width(DEPTH)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           rd_clr,
    input  logic                           wr_clr,
    input  logic                           rd_en,
    input  logic                           wr_en,
    input  logic                           max_mode,
    input  logic [NUM_FIFO-1:0]            lane_mask,
    input  logic [DATA_WIDTH*NUM_FIFO-1:0] data_in,
    output logic [DATA_WIDTH*NUM_FIFO-1:0] data_out,
    output logic                           data_valid,
    output logic [PW-1:0]                  count,
    output logic                           full,
    output logic                           empty,
    output logic                           overflow,
    output logic                           underflow
);

    localparam int AW = PW - 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          valid_q, valid_d;
    ctl_t          ctl;

    assign count = wr_ptr_q - rd_ptr_q;
    assign full  = (count == PW'(DEPTH));
    assign empty = (count == '0);

    // Any clear suppresses the data-path operations of that cycle.
    always_comb begin
        ctl = '0;
        if (!(rd_clr || wr_clr)) begin
            if (wr_en && max_mode) begin
                ctl.merge   = !empty;
                ctl.unf_set = empty;
            end else begin
                ctl.pop     = rd_en && !empty;
                ctl.unf_set = rd_en && empty;
                ctl.push    = wr_en && (!full || ctl.pop);
                ctl.ovf_set = wr_en && !ctl.push;
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_clr)                     wr_ptr_d = '0;
        else if (ctl.push || ctl.merge) wr_ptr_d = wr_ptr_q + PW'(1);
        if (rd_clr)                     rd_ptr_d = '0;
        else if (ctl.pop || ctl.merge)  rd_ptr_d = rd_ptr_q + PW'(1);
        ovf_d   = (rd_clr && wr_clr) ? 1'b0 : (ovf_q || ctl.ovf_set);
        unf_d   = (rd_clr && wr_clr) ? 1'b0 : (unf_q || ctl.unf_set);
        valid_d = ctl.pop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            valid_q  <= valid_d;
        end
    end

    assign overflow   = ovf_q;
    assign underflow  = unf_q;
    assign data_valid = valid_q;

    for (genvar g = 0; g < NUM_FIFO; g++) begin : g_lane
        maxpool_lane_mem #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH),
            .SIGNED     (SIGNED)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .push_i    (ctl.push),
            .merge_i   (ctl.merge),
            .pop_i     (ctl.pop),
            .mask_i    (lane_mask[g]),
            .din_i     (data_in[lane_lsb(g, DATA_WIDTH) +: DATA_WIDTH]),
            .wr_addr_i (wr_ptr_q[AW-1:0]),
            .rd_addr_i (rd_ptr_q[AW-1:0]),
            .dout_o    (data_out[lane_lsb(g, DATA_WIDTH) +: DATA_WIDTH])
        );
    end

endmodule

// File: tb/tb_maxpool_fifo_bank.sv
// tb/tb_maxpool_fifo_bank.sv - self-checking bench for maxpool_fifo_bank
module tb_maxpool_fifo_bank;

    localparam int DW = 16;
    localparam int DP = 16;
    localparam int NF = 16;
    localparam int RW = DW * NF;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rd_clr, wr_clr, rd_en, wr_en, max_mode;
    logic [NF-1:0] lane_mask;
    logic [RW-1:0] data_in;
    logic [RW-1:0] data_out;
    logic          data_valid;
    logic [4:0]    count;
    logic          full, empty, overflow, underflow;

    maxpool_fifo_bank #(.DATA_WIDTH(DW), .DEPTH(DP), .NUM_FIFO(NF), .SIGNED(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_clr     (rd_clr),
        .wr_clr     (wr_clr),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .max_mode   (max_mode),
        .lane_mask  (lane_mask),
        .data_in    (data_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: the FIFO as a queue of rows plus a log of every row written since clear.
    logic [RW-1:0] q[$];
    logic [RW-1:0] hist[$];
    logic [RW-1:0] m_dout;
    logic          m_dv, m_ovf, m_unf;

    typedef struct {
        logic          rc, wc, re, we, mm;
        logic [NF-1:0] mk;
        logic [RW-1:0] d;
        logic [4:0]    c;
        logic          fu, em, ov, un, dv;
        logic [DW-1:0] l0, l1;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [RW-1:0] alt(input logic [DW-1:0] ev, input logic [DW-1:0] od);
        logic [RW-1:0] r;
        for (int i = 0; i < NF; i++) r[i*DW +: DW] = (i % 2 == 0) ? ev : od;
        return r;
    endfunction

    function automatic logic [RW-1:0] fill(input logic [DW-1:0] v);
        return alt(v, v);
    endfunction

    task automatic model_reset();
        q.delete();
        hist.delete();
        m_dout = '0;
        m_dv   = 1'b0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    task automatic model_apply(input logic rc, wc, re, we, mm, input logic [NF-1:0] mk,
                               input logic [RW-1:0] d);
        logic [RW-1:0] h, r;
        logic          popped;
        int            pre;
        m_dv = 1'b0;
        if (rc || wc) begin
            if (rc && wc) begin
                q.delete();
                hist.delete();
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end else if (rc) begin
                q = hist;
            end
        end else if (we && mm) begin
            if (q.size() == 0) m_unf = 1'b1;
            else begin
                h = q.pop_front();
                for (int i = 0; i < NF; i++)
                    r[i*DW +: DW] = (mk[i] && ($signed(d[i*DW +: DW]) > $signed(h[i*DW +: DW])))
                                    ? d[i*DW +: DW] : h[i*DW +: DW];
                q.push_back(r);
                hist.push_back(r);
            end
        end else begin
            pre    = q.size();
            popped = 1'b0;
            if (re) begin
                if (pre == 0) m_unf = 1'b1;
                else begin
                    m_dout = q.pop_front();
                    m_dv   = 1'b1;
                    popped = 1'b1;
                end
            end
            if (we) begin
                if (pre < DP || popped) begin
                    for (int i = 0; i < NF; i++) r[i*DW +: DW] = mk[i] ? d[i*DW +: DW] : 16'h8000;
                    q.push_back(r);
                    hist.push_back(r);
                end else m_ovf = 1'b1;
            end
        end
    endtask

    task automatic cmp_model();
        chk("count", RW'(count), RW'(q.size()));
        chk("full", RW'(full), RW'(q.size() == DP));
        chk("empty", RW'(empty), RW'(q.size() == 0));
        chk("overflow", RW'(overflow), RW'(m_ovf));
        chk("underflow", RW'(underflow), RW'(m_unf));
        chk("data_valid", RW'(data_valid), RW'(m_dv));
        chk("data_out", data_out, m_dout);
    endtask

    task automatic step(input logic rc, wc, re, we, mm, input logic [NF-1:0] mk,
                        input logic [RW-1:0] d);
        rd_clr = rc; wr_clr = wc; rd_en = re; wr_en = we; max_mode = mm;
        lane_mask = mk; data_in = d;
        model_apply(rc, wc, re, we, mm, mk, d);
        @(posedge clk);
        #1;
        cmp_model();
        rd_clr = 0; wr_clr = 0; rd_en = 0; wr_en = 0; max_mode = 0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_data_out"}, data_out, '0);
        chk({tag, "_data_valid"}, RW'(data_valid), '0);
        chk({tag, "_count"}, RW'(count), '0);
        chk({tag, "_empty"}, RW'(empty), RW'(1));
        chk({tag, "_full"}, RW'(full), '0);
        chk({tag, "_overflow"}, RW'(overflow), '0);
        chk({tag, "_underflow"}, RW'(underflow), '0);
    endtask

    initial begin
        logic [RW-1:0] a_row, b_row;
        a_row = alt(16'd5, 16'hFFFD);
        b_row = alt(16'd2, 16'd7);
        //          rc wc re we mm  mask      data           c  fu em ov un dv  l0       l1
        tbl[0] = '{0, 0, 0, 1, 0, 16'hFFFF, a_row,         1, 0, 0, 0, 0, 0, 16'h0,    16'h0};
        tbl[1] = '{0, 0, 0, 1, 1, 16'hFFFF, b_row,         1, 0, 0, 0, 0, 0, 16'h0,    16'h0};
        tbl[2] = '{0, 0, 1, 0, 0, 16'hFFFF, '0,            0, 0, 1, 0, 0, 1, 16'd5,    16'd7};
        tbl[3] = '{0, 0, 0, 1, 0, 16'hFFFE, fill(16'h1234), 1, 0, 0, 0, 0, 0, 16'd5,   16'd7};
        tbl[4] = '{0, 0, 0, 1, 1, 16'hFFFE, fill(16'h7FFF), 1, 0, 0, 0, 0, 0, 16'd5,   16'd7};
        tbl[5] = '{0, 0, 1, 0, 0, 16'hFFFF, '0,            0, 0, 1, 0, 0, 1, 16'h8000, 16'h7FFF};
        tbl[6] = '{0, 0, 1, 0, 0, 16'hFFFF, '0,            0, 0, 1, 0, 1, 0, 16'h8000, 16'h7FFF};
        tbl[7] = '{0, 0, 1, 1, 1, 16'hFFFF, b_row,         0, 0, 1, 0, 1, 0, 16'h8000, 16'h7FFF};
        tbl[8] = '{1, 1, 0, 0, 0, 16'hFFFF, '0,            0, 0, 1, 0, 0, 0, 16'h8000, 16'h7FFF};

        rst_n = 0; rd_clr = 0; wr_clr = 0; rd_en = 0; wr_en = 0; max_mode = 0;
        lane_mask = '1; data_in = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        #1;
        chk_reset_outputs("reset");

        for (int k = 0; k < 9; k++) begin
            step(tbl[k].rc, tbl[k].wc, tbl[k].re, tbl[k].we, tbl[k].mm, tbl[k].mk, tbl[k].d);
            chk($sformatf("tbl%0d_count", k), RW'(count), RW'(tbl[k].c));
            chk($sformatf("tbl%0d_flags", k), RW'({full, empty, overflow, underflow, data_valid}),
                RW'({tbl[k].fu, tbl[k].em, tbl[k].ov, tbl[k].un, tbl[k].dv}));
            chk($sformatf("tbl%0d_lane0", k), RW'(data_out[0 +: DW]), RW'(tbl[k].l0));
            chk($sformatf("tbl%0d_lane1", k), RW'(data_out[DW +: DW]), RW'(tbl[k].l1));
        end

        // Fill to DEPTH, then exercise the full boundary.
        for (int i = 0; i < DP; i++) step(0, 0, 0, 1, 0, '1, fill(DW'(i)));
        chk("fill_count", RW'(count), RW'(16));
        chk("fill_full", RW'(full), RW'(1));
        step(0, 0, 1, 1, 0, '1, fill(16'd100));
        chk("full_pushpop_dv", RW'(data_valid), RW'(1));
        chk("full_pushpop_lane0", RW'(data_out[0 +: DW]), RW'(0));
        chk("full_pushpop_count", RW'(count), RW'(16));
        chk("full_pushpop_ovf", RW'(overflow), RW'(0));
        step(0, 0, 0, 1, 0, '1, fill(16'd101));
        chk("overflow_set", RW'(overflow), RW'(1));
        chk("overflow_count", RW'(count), RW'(16));
        step(0, 0, 1, 1, 1, '1, fill(16'd50));
        chk("merge_rd_dv", RW'(data_valid), RW'(0));
        chk("merge_rd_count", RW'(count), RW'(16));
        for (int i = 0; i < DP; i++) begin
            step(0, 0, 1, 0, 0, '1, '0);
            chk($sformatf("drain%0d_dv", i), RW'(data_valid), RW'(1));
        end

        // Replay from address 0 after a read-side rewind.
        step(1, 1, 0, 0, 0, '1, '0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, '1, fill(DW'(10 + i)));
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, '1, '0);
        step(1, 0, 0, 0, 0, '1, '0);
        chk("replay_count", RW'(count), RW'(4));
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, 0, 0, '1, '0);
            chk($sformatf("replay%0d_lane0", i), RW'(data_out[0 +: DW]), RW'(10 + i));
        end

        // Asynchronous reset in the middle of a pop burst.
        step(0, 0, 0, 1, 0, '1, fill(16'h55));
        step(0, 0, 0, 1, 0, '1, fill(16'h66));
        rd_en = 1;
        model_apply(0, 0, 1, 0, 0, '1, '0);
        @(posedge clk);
        #1;
        cmp_model();
        #2;
        rst_n = 0;
        #1;
        chk_reset_outputs("async_reset");
        @(negedge clk);
        rst_n = 1;
        rd_en = 0;
        model_reset();

        for (int n = 0; n < 400; n++) begin
            logic we_r, mm_r;
            we_r = ($urandom_range(0, 9) < 6);
            mm_r = we_r && ($urandom_range(0, 3) == 0);
            step(0, 0, $urandom_range(0, 1) == 1, we_r, mm_r, NF'($urandom),
                 {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
